mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/mux_scan_if.sv | 11 +
 rtl/mux_scan_settle.sv | 22 ++
 rtl/mux_scan_ctrl.sv | 111 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the strobed 16:1 selector scan controller.
package mux_scan_pkg;
    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE
    } state_t;
endpackage

// File: rtl/mux_scan_if.sv
// Select/strobe/return bus between the scan controller and the strobed selector.
interface mux_scan_if;
    import mux_scan_pkg::*;

    logic [SEL_W-1:0] SEL;
    logic             STB;
    logic             W_IN;

    modport master (output SEL, output STB, input W_IN);
    modport slave  (input SEL, input STB, output W_IN);
endinterface

// File: rtl/mux_scan_settle.sv
// Per-channel settle counter: clear has priority over enable, tc flags the last settle cycle.
module mux_scan_settle
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + CNT_W'(1);
    end

    assign tc = (cnt == CNT_W'(SETTLE - 1));
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans all 16 selector channels (settle, then sample each) and publishes the word with
// a one-cycle DONE and a change flag. Every output comes straight from a flop.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              CONT,
    input  logic              ABORT,
    mux_scan_if.master        sbus,
    output logic [NUM_CH-1:0] DATA_OUT,
    output logic              DONE,
    output logic              CHG,
    output logic              BUSY
);
    state_t             state, nxt;
    logic [SEL_W-1:0]   sel_q, sel_nxt;
    logic               stb_q;
    logic [NUM_CH-1:0]  buf_q, buf_nxt, cap;
    logic [NUM_CH-1:0]  data_nxt;
    logic               done_nxt, chg_nxt;
    logic               tc;

    mux_scan_settle #(.SETTLE(SETTLE)) u_settle (
        .clk (CLK),
        .rst (RST),
        .clr (state != ST_SETTLE),
        .en  (state == ST_SETTLE),
        .tc  (tc)
    );

    assign sbus.SEL = sel_q;
    assign sbus.STB = stb_q;

    always_comb begin
        nxt      = state;
        sel_nxt  = sel_q;
        buf_nxt  = buf_q;
        data_nxt = DATA_OUT;
        done_nxt = 1'b0;
        chg_nxt  = CHG;
        // Selector returns the inverted datum; the word under construction includes this edge's bit.
        cap         = buf_q;
        cap[sel_q]  = ~sbus.W_IN;
        unique case (state)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    nxt     = ST_SETTLE;
                    sel_nxt = '0;
                end
            end
            ST_SETTLE: begin
                if (ABORT) begin
                    nxt     = ST_IDLE;
                    sel_nxt = '0;
                    buf_nxt = '0;
                end else if (tc) begin
                    nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (ABORT) begin
                    nxt     = ST_IDLE;
                    sel_nxt = '0;
                    buf_nxt = '0;
                end else begin
                    buf_nxt = cap;
                    if (sel_q == SEL_W'(NUM_CH - 1)) begin
                        data_nxt = cap;
                        done_nxt = 1'b1;
                        chg_nxt  = (cap != DATA_OUT);
                        sel_nxt  = '0;
                        nxt      = CONT ? ST_SETTLE : ST_IDLE;
                    end else begin
                        sel_nxt = sel_q + SEL_W'(1);
                        nxt     = ST_SETTLE;
                    end
                end
            end
            default: begin
                nxt     = ST_IDLE;
                sel_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            sel_q    <= '0;
            stb_q    <= 1'b1;
            buf_q    <= '0;
            DATA_OUT <= '0;
            DONE     <= 1'b0;
            CHG      <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= nxt;
            sel_q    <= sel_nxt;
            stb_q    <= (nxt == ST_IDLE);
            buf_q    <= buf_nxt;
            DATA_OUT <= data_nxt;
            DONE     <= done_nxt;
            CHG      <= chg_nxt;
            BUSY     <= (nxt != ST_IDLE);
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3) each driving a strobed
// inverting 16:1 selector model; table of single scans plus continuous/abort/settle/reset sequences.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, CONT, ABORT, start_a, start_b, corrupt;
    logic [15:0] e;
    logic [15:0] data_a, data_b;
    logic        done_a, chg_a, busy_a, done_b, chg_b, busy_b;
    bit          which;
    int          checks = 0;
    int          failures = 0;

    mux_scan_if bus_a();
    mux_scan_if bus_b();

    // Selector model: strobe high forces output high, else output is the inverted channel datum.
    // On instance B, corrupt returns the wrong polarity (used only during settle cycles).
    assign bus_a.W_IN = bus_a.STB ? 1'b1 : ~e[bus_a.SEL];
    assign bus_b.W_IN = bus_b.STB ? 1'b1 : (corrupt ? e[bus_b.SEL] : ~e[bus_b.SEL]);

    mux_scan_ctrl #(.SETTLE(1)) dut_a (
        .CLK(CLK), .RST(RST), .START(start_a), .CONT(CONT), .ABORT(ABORT),
        .sbus(bus_a), .DATA_OUT(data_a), .DONE(done_a), .CHG(chg_a), .BUSY(busy_a)
    );

    mux_scan_ctrl #(.SETTLE(3)) dut_b (
        .CLK(CLK), .RST(RST), .START(start_b), .CONT(CONT), .ABORT(ABORT),
        .sbus(bus_b), .DATA_OUT(data_b), .DONE(done_b), .CHG(chg_b), .BUSY(busy_b)
    );

    wire [15:0] o_data = which ? data_b : data_a;
    wire        o_done = which ? done_b : done_a;
    wire        o_chg  = which ? chg_b  : chg_a;
    wire        o_busy = which ? busy_b : busy_a;
    wire        o_stb  = which ? bus_b.STB : bus_a.STB;
    wire [3:0]  o_sel  = which ? bus_b.SEL : bus_a.SEL;

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] e;
        logic [15:0] exp_d;
        logic        exp_c;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (which) start_b = v;
        else       start_a = v;
    endtask

    // Runs one scan of 16*(s+1) edges, checking {DONE,BUSY,STB,SEL} after every edge.
    task automatic scan(input int s, input bit do_start, input bit cont,
                        input logic [15:0] exp_d, input logic exp_c,
                        input int glitch, input string tag);
        int last = 16 * (s + 1);
        CONT = cont;
        if (do_start) begin
            drive_start(1'b1);
            @(posedge CLK); #1;
            drive_start(1'b0);
        end
        for (int n = 1; n <= last; n++) begin
            corrupt = ((n % (s + 1)) != 0);
            if (n == glitch) drive_start(1'b1);
            @(posedge CLK); #1;
            drive_start(1'b0);
            if (n < last)
                chk($sformatf("%s_edge%0d", tag, n), {o_done, o_busy, o_stb, o_sel},
                    {1'b0, 1'b1, 1'b0, 4'(n / (s + 1))});
            else begin
                chk($sformatf("%s_end", tag), {o_done, o_busy, o_stb, o_sel},
                    {1'b1, cont, ~cont, 4'h0});
                chk($sformatf("%s_data", tag), o_data, exp_d);
                chk($sformatf("%s_chg", tag), o_chg, exp_c);
            end
        end
        corrupt = 1'b0;
    endtask

    task automatic idle_watch(input int cycles, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK); #1;
            seen |= o_done;
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        tbl[0] = '{16'hA5C3, 16'hA5C3, 1'b1};
        tbl[1] = '{16'hA5C3, 16'hA5C3, 1'b0};
        tbl[2] = '{16'h0001, 16'h0001, 1'b1};
        tbl[3] = '{16'h0001, 16'h0001, 1'b0};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1};
        tbl[5] = '{16'h8000, 16'h8000, 1'b1};

        RST = 1'b1; CONT = 1'b0; ABORT = 1'b0; start_a = 1'b0; start_b = 1'b0;
        corrupt = 1'b0; e = 16'h0000; which = 1'b0;

        // Reset held two cycles
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ctl", {done_a, busy_a, bus_a.STB, bus_a.SEL}, {1'b0, 1'b0, 1'b1, 4'h0});
        chk("rst_data", data_a, 16'h0000);
        chk("rst_chg", chg_a, 1'b0);
        chk("rst_data_b", data_b, 16'h0000);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Single scans from the table, then one idle edge to see DONE drop and CHG hold
        for (int i = 0; i < 6; i++) begin
            e = tbl[i].e;
            scan(1, 1'b1, 1'b0, tbl[i].exp_d, tbl[i].exp_c, 0, $sformatf("tbl%0d", i));
            @(posedge CLK); #1;
            chk($sformatf("tbl%0d_after", i), {o_done, o_busy, o_stb, o_sel},
                {1'b0, 1'b0, 1'b1, 4'h0});
            chk($sformatf("tbl%0d_chg_hold", i), o_chg, tbl[i].exp_c);
        end

        // Continuous walking-one scans; E changes right after each DONE
        for (int i = 0; i < 4; i++) begin
            logic [15:0] w;
            w = 16'h0001 << i;
            e = w;
            scan(1, (i == 0), (i < 3), w, 1'b1, 0, $sformatf("cont%0d", i));
        end
        CONT = 1'b0;

        // Abort while SEL=7
        e = 16'hFFFF;
        start_a = 1'b1;
        @(posedge CLK); #1;
        start_a = 1'b0;
        repeat (14) @(posedge CLK);
        #1;
        chk("abort_sel7", o_sel, 4'd7);
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        chk("abort_ctl", {o_done, o_busy, o_stb, o_sel}, {1'b0, 1'b0, 1'b1, 4'h0});
        chk("abort_data", o_data, 16'h0008);
        chk("abort_chg", o_chg, 1'b1);
        idle_watch(40, "abort_no_done");

        // ABORT beats START in IDLE
        ABORT = 1'b1; start_a = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0; start_a = 1'b0;
        chk("abort_start_idle", {o_busy, o_stb}, {1'b0, 1'b1});

        // START pulsed mid-scan must not restart or stretch the scan
        e = 16'h1234;
        scan(1, 1'b1, 1'b0, 16'h1234, 1'b1, 9, "glitch");

        // SETTLE=3 instance with wrong-polarity data during settle cycles
        which = 1'b1;
        e = 16'h5A3C;
        scan(3, 1'b1, 1'b0, 16'h5A3C, 1'b1, 0, "settle3");
        which = 1'b0;

        // Reset mid-scan: no DONE, everything back to reset values
        e = 16'hFFFF;
        start_a = 1'b1;
        @(posedge CLK); #1;
        start_a = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("midrst_ctl", {o_done, o_busy, o_stb, o_sel}, {1'b0, 1'b0, 1'b1, 4'h0});
        chk("midrst_data", o_data, 16'h0000);
        chk("midrst_chg", o_chg, 1'b0);
        idle_watch(40, "midrst_no_done");

        // First scan after reset compares against zero
        e = 16'h0000;
        scan(1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, "zero_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
